// File: rtl/ram2_arb_pkg.sv
// rtl/ram2_arb_pkg.sv - shared types and constants for the RAM2 SRAM arbiter
package ram2_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETUP  = 2'd1,
        ARB_ACCESS = 2'd2,
        ARB_HOLD   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } arb_owner_t;

    // Width of the strobe-phase cycle counter; bounds ACCESS_CYCLES to 256.
    localparam int ARB_ACC_CNT_W = 8;

endpackage

// File: rtl/ram2_sat_counter.sv
// rtl/ram2_sat_counter.sv - 16-bit saturating event counter with synchronous clear
module ram2_sat_counter (
    input  logic        i_clk,
    input  logic        i_clr,
    input  logic        i_inc,
    output logic [15:0] o_count
);

    logic [15:0] r_count;

    // Count qualifying cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= 16'd0;
        end else if (i_inc && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ram2_arbiter.sv
// rtl/ram2_arbiter.sv - registered SRAM cycle sequencer shared by fetch and data ports (optional ARB_IF_STALL_CNT_EN)
module ram2_arbiter
    import ram2_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16
) (
    input  logic              arbi_clk,
    input  logic              arbi_rst,
    input  logic              arbi_if_req,
    input  logic [ADDR_W-1:0] arbi_if_addr,
    output logic              arbo_if_ack,
    output logic [DATA_W-1:0] arbo_if_data,
    input  logic              arbi_mem_req,
    input  logic              arbi_mem_we,
    input  logic [ADDR_W-1:0] arbi_mem_addr,
    input  logic [DATA_W-1:0] arbi_mem_wdata,
    output logic              arbo_mem_ack,
    output logic [DATA_W-1:0] arbo_mem_rdata,
    output logic              arbo_pause_request,
    output logic              arbo_ram_en,
    output logic              arbo_ram_oe,
    output logic              arbo_ram_we,
    output logic [ADDR_W-1:0] arbo_ram_addr,
    output logic [DATA_W-1:0] arbo_ram_wdata,
    output logic              arbo_ram_drive,
    input  logic [DATA_W-1:0] arbi_ram_rdata,
    output logic [15:0]       arbo_if_stall_cycles
);

    localparam logic [ARB_ACC_CNT_W-1:0] LP_ACC_LAST = ARB_ACC_CNT_W'(ACCESS_CYCLES - 1);

    arb_state_t               r_state;
    arb_owner_t               r_owner;
    logic                     r_is_write;
    logic [ARB_ACC_CNT_W-1:0] r_acc_cnt;
    logic                     r_ram_en;
    logic                     r_ram_oe;
    logic                     r_ram_we;
    logic [ADDR_W-1:0]        r_ram_addr;
    logic [DATA_W-1:0]        r_ram_wdata;
    logic                     r_ram_drive;
    logic                     r_if_ack;
    logic                     r_mem_ack;
    logic [DATA_W-1:0]        r_if_data;
    logic [DATA_W-1:0]        r_mem_rdata;

    // SRAM cycle FSM: latch a transaction in IDLE, then walk SETUP/ACCESS/HOLD with registered strobes.
    always_ff @(posedge arbi_clk) begin
        if (arbi_rst) begin
            r_state     <= ARB_IDLE;
            r_owner     <= OWNER_IF;
            r_is_write  <= 1'b0;
            r_acc_cnt   <= '0;
            r_ram_en    <= 1'b1;
            r_ram_oe    <= 1'b1;
            r_ram_we    <= 1'b1;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_drive <= 1'b0;
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
        end else begin
            r_if_ack  <= 1'b0;
            r_mem_ack <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    // Data port wins any tie; the fetch simply waits for the next IDLE.
                    if (arbi_mem_req) begin
                        r_state     <= ARB_SETUP;
                        r_owner     <= OWNER_MEM;
                        r_is_write  <= arbi_mem_we;
                        r_ram_en    <= 1'b0;
                        r_ram_addr  <= arbi_mem_addr;
                        r_ram_wdata <= arbi_mem_wdata;
                        r_ram_drive <= arbi_mem_we;
                    end else if (arbi_if_req) begin
                        r_state     <= ARB_SETUP;
                        r_owner     <= OWNER_IF;
                        r_is_write  <= 1'b0;
                        r_ram_en    <= 1'b0;
                        r_ram_addr  <= arbi_if_addr;
                        r_ram_drive <= 1'b0;
                    end
                end
                ARB_SETUP: begin
                    // Address has had a full cycle to settle; open exactly one strobe.
                    r_state   <= ARB_ACCESS;
                    r_acc_cnt <= '0;
                    if (r_is_write) begin
                        r_ram_we <= 1'b0;
                    end else begin
                        r_ram_oe <= 1'b0;
                    end
                end
                ARB_ACCESS: begin
                    if (r_acc_cnt == LP_ACC_LAST) begin
                        r_state  <= ARB_HOLD;
                        r_ram_oe <= 1'b1;
                        r_ram_we <= 1'b1;
                        if (r_owner == OWNER_MEM) begin
                            r_mem_ack <= 1'b1;
                            if (!r_is_write) begin
                                r_mem_rdata <= arbi_ram_rdata;
                            end
                        end else begin
                            r_if_ack  <= 1'b1;
                            r_if_data <= arbi_ram_rdata;
                        end
                    end else begin
                        r_acc_cnt <= r_acc_cnt + ARB_ACC_CNT_W'(1);
                    end
                end
                ARB_HOLD: begin
                    // Strobes are already high; release the chip and the bus after this cycle.
                    r_state     <= ARB_IDLE;
                    r_ram_en    <= 1'b1;
                    r_ram_drive <= 1'b0;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign arbo_if_ack        = r_if_ack;
    assign arbo_if_data       = r_if_data;
    assign arbo_mem_ack       = r_mem_ack;
    assign arbo_mem_rdata     = r_mem_rdata;
    assign arbo_ram_en        = r_ram_en;
    assign arbo_ram_oe        = r_ram_oe;
    assign arbo_ram_we        = r_ram_we;
    assign arbo_ram_addr      = r_ram_addr;
    assign arbo_ram_wdata     = r_ram_wdata;
    assign arbo_ram_drive     = r_ram_drive;
    assign arbo_pause_request = arbi_mem_req & ~r_mem_ack;

`ifdef ARB_IF_STALL_CNT_EN
    logic w_if_stalled;

    assign w_if_stalled = arbi_if_req & ~r_if_ack;

    ram2_sat_counter u_if_stall_cnt (
        .i_clk   (arbi_clk),
        .i_clr   (arbi_rst),
        .i_inc   (w_if_stalled),
        .o_count (arbo_if_stall_cycles)
    );
`else
    assign arbo_if_stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_ram2_arbiter.sv
// tb/tb_ram2_arbiter.sv - scoreboard bench for ram2_arbiter
module tb_ram2_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [15:0] if_data;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        pause;
    logic        ram_en;
    logic        ram_oe;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_drive;
    logic [15:0] ram_rdata;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    ram2_arbiter #(.ACCESS_CYCLES(2), .ADDR_W(16), .DATA_W(16)) dut (
        .arbi_clk             (clk),
        .arbi_rst             (rst),
        .arbi_if_req          (if_req),
        .arbi_if_addr         (if_addr),
        .arbo_if_ack          (if_ack),
        .arbo_if_data         (if_data),
        .arbi_mem_req         (mem_req),
        .arbi_mem_we          (mem_we),
        .arbi_mem_addr        (mem_addr),
        .arbi_mem_wdata       (mem_wdata),
        .arbo_mem_ack         (mem_ack),
        .arbo_mem_rdata       (mem_rdata),
        .arbo_pause_request   (pause),
        .arbo_ram_en          (ram_en),
        .arbo_ram_oe          (ram_oe),
        .arbo_ram_we          (ram_we),
        .arbo_ram_addr        (ram_addr),
        .arbo_ram_wdata       (ram_wdata),
        .arbo_ram_drive       (ram_drive),
        .arbi_ram_rdata       (ram_rdata),
        .arbo_if_stall_cycles (stall_cnt)
    );

    typedef struct {
        bit          port;
        bit          rd;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          mon_en = 1'b1;
    int          wr_edges = 0;
    logic [15:0] wr_last_addr = 16'd0;
    logic [15:0] wr_last_data = 16'd0;
    bit          prev_low = 1'b0;
    logic [15:0] prev_addr = 16'd0;

    function automatic logic [15:0] ram_val(input logic [15:0] a);
        case (a)
            16'h1234: ram_val = 16'hBEEF;
            16'h0100: ram_val = 16'hA5A5;
            16'h0200: ram_val = 16'h3C3C;
            16'h0300: ram_val = 16'h1111;
            16'h0400: ram_val = 16'h2222;
            16'h0600: ram_val = 16'h6666;
            default:  ram_val = 16'h0000;
        endcase
    endfunction

    assign ram_rdata = (!ram_en && !ram_oe) ? ram_val(ram_addr) : 16'hDEAD;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!ram_en && !ram_we) begin
            wr_edges     <= wr_edges + 1;
            wr_last_addr <= ram_addr;
            wr_last_data <= ram_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input bit port, input bit rd, input logic [15:0] d, input int c);
        exp_t e;
        e.port = port;
        e.rd   = rd;
        e.data = d;
        e.cyc  = c;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en && (if_ack || mem_ack)) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: if_ack=%0b mem_ack=%0b with no pending expectation (cycle %0d)", if_ack, mem_ack, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("ack_port", {31'd0, mem_ack}, {31'd0, mon_e.port});
                chk("ack_both", {31'd0, if_ack & mem_ack}, 32'd0);
                chk("ack_cycle", cyc, mon_e.cyc);
                if (mon_e.rd) begin
                    chk("ack_data", mem_ack ? mem_rdata : if_data, mon_e.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("oe_we_exclusive", {31'd0, ~ram_oe & ~ram_we}, 32'd0);
        if (prev_low && (!ram_oe || !ram_we)) begin
            chk("addr_stable_strobe", ram_addr, prev_addr);
        end
        prev_low  = !ram_oe || !ram_we;
        prev_addr = ram_addr;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0;
        int wr0;
        rst = 1'b1;
        if_req = 1'b0; if_addr = 16'd0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 16'd0; mem_wdata = 16'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_en", ram_en, 1);
        chk("rst_oe", ram_oe, 1);
        chk("rst_we", ram_we, 1);
        chk("rst_drive", ram_drive, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_acks", {if_ack, mem_ack}, 0);
        chk("rst_data", {if_data, mem_rdata}, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_pause", pause, 0);
        rst = 1'b0;

        // Simultaneous reads: data port first, fetch next
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            if (k == 0) begin
                t0 = cyc;
                mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0100;
                if_req = 1'b1; if_addr = 16'h0200;
                push_exp(1'b1, 1'b1, 16'hA5A5, t0 + 4);
                push_exp(1'b0, 1'b1, 16'h3C3C, t0 + 9);
            end
            #1;
            chk("s3_pause", pause, (k <= 3) ? 1 : 0);
            chk("s3_en", ram_en, ((k >= 1 && k <= 4) || (k >= 6 && k <= 9)) ? 0 : 1);
            chk("s3_oe", ram_oe, (k == 2 || k == 3 || k == 7 || k == 8) ? 0 : 1);
            if (k == 2) chk("s3_addr_mem", ram_addr, 16'h0100);
            if (k == 7) chk("s3_addr_if", ram_addr, 16'h0200);
            if (mem_ack) mem_req = 1'b0;
            if (if_ack) if_req = 1'b0;
        end
`ifdef ARB_IF_STALL_CNT_EN
        chk("s3_stall_cnt", stall_cnt, 9);
`else
        chk("s3_stall_cnt", stall_cnt, 0);
`endif

        // Fetch read
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                t0 = cyc;
                if_req = 1'b1; if_addr = 16'h1234;
                push_exp(1'b0, 1'b1, 16'hBEEF, t0 + 4);
            end
            #1;
            chk("s1_en", ram_en, (k >= 1 && k <= 4) ? 0 : 1);
            chk("s1_oe", ram_oe, (k == 2 || k == 3) ? 0 : 1);
            chk("s1_we", ram_we, 1);
            chk("s1_pause", pause, 0);
            if (k == 1) chk("s1_addr", ram_addr, 16'h1234);
            if (if_ack) if_req = 1'b0;
        end

        // Data write
        wr0 = wr_edges;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k == 0) begin
                t0 = cyc;
                mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h8000; mem_wdata = 16'h00FF;
                push_exp(1'b1, 1'b0, 16'h0000, t0 + 4);
            end
            if (k == 2) begin
                mem_addr = 16'h4444; mem_wdata = 16'h9999;
            end
            #1;
            chk("s2_we", ram_we, (k == 2 || k == 3) ? 0 : 1);
            chk("s2_oe", ram_oe, 1);
            chk("s2_drive", ram_drive, (k >= 1 && k <= 4) ? 1 : 0);
            chk("s2_pause", pause, (k <= 3) ? 1 : 0);
            if (k == 3) begin
                chk("s2_addr", ram_addr, 16'h8000);
                chk("s2_wdata", ram_wdata, 16'h00FF);
            end
            if (mem_ack) mem_req = 1'b0;
        end
        chk("s2_wr_edges", wr_edges - wr0, 2);
        chk("s2_wr_addr", wr_last_addr, 16'h8000);
        chk("s2_wr_data", wr_last_data, 16'h00FF);
        chk("s2_rdata_held", mem_rdata, 16'hA5A5);
        chk("s2_if_data_held", if_data, 16'hBEEF);

        // Data read arrives during fetch ACCESS
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            if (k == 0) begin
                t0 = cyc;
                if_req = 1'b1; if_addr = 16'h0300;
                push_exp(1'b0, 1'b1, 16'h1111, t0 + 4);
            end
            if (k == 2) begin
                mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0400;
                push_exp(1'b1, 1'b1, 16'h2222, t0 + 9);
            end
            #1;
            chk("s4_pause", pause, (k >= 2 && k <= 8) ? 1 : 0);
            chk("s4_en", ram_en, ((k >= 1 && k <= 4) || (k >= 6 && k <= 9)) ? 0 : 1);
            if (mem_ack) mem_req = 1'b0;
            if (if_ack) if_req = 1'b0;
        end
        chk("s4_if_data_held", if_data, 16'h1111);

        // Reset during write ACCESS, then a fresh read
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k == 0) begin
                t0 = cyc;
                mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0500; mem_wdata = 16'h7777;
            end
            if (k == 3) rst = 1'b0;
            if (k == 4) begin
                mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0600;
                push_exp(1'b1, 1'b1, 16'h6666, t0 + 8);
            end
            #1;
            if (k == 2) begin
                chk("s5_we_before_rst", ram_we, 0);
                rst = 1'b1;
                mem_req = 1'b0;
            end
            if (k == 3) begin
                chk("s5_en", ram_en, 1);
                chk("s5_oe", ram_oe, 1);
                chk("s5_we", ram_we, 1);
                chk("s5_drive", ram_drive, 0);
                chk("s5_rdata_clr", mem_rdata, 0);
                chk("s5_if_data_clr", if_data, 0);
                chk("s5_stall_clr", stall_cnt, 0);
            end
            if (k >= 4) chk("s5_pause", pause, (k <= 7) ? 1 : 0);
            if (k >= 4 && mem_ack) mem_req = 1'b0;
        end

`ifdef ARB_IF_STALL_CNT_EN
        // Fetch starved behind a permanently requesting data port
        mon_en = 1'b0;
        if_req = 1'b1; if_addr = 16'h0300;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0100;
        repeat (70000) @(negedge clk);
        if_req = 1'b0;
        mem_req = 1'b0;
        repeat (10) @(negedge clk);
        chk("s6_stall_sat", stall_cnt, 16'hFFFF);
        mon_en = 1'b1;
`else
        chk("s6_stall_off", stall_cnt, 0);
`endif

        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
